psc_trigger_receiver: RTL and testbench
=======================================

Name: psc_trigger_receiver

Overview:
Receive end of the PSC trigger serial link. The block oversamples the 10 Mbit/s line in the 50 MHz domain and deframes 10-bit words. It reassembles fixed-length packets, checks the trailing CRC-8, and emits a one-cycle trigger pulse when a valid trigger packet arrives. It sits at the power-supply-controller side, driven by the psc_output line of the transmitter.

Parameters:
CLKS_PER_BIT, 5, clk cycles per line bit (50 MHz / 10 Mbit/s).
PKT_BYTES, 8, bytes per packet including the trailing CRC byte; range 2..16.
TRIGGER_HDR, 8'hA5, byte-0 value that marks a trigger packet.
GAP_BITS, 20, idle bit-times (line low) after which a partial packet is discarded.

Ports:
clk  in  1  system clock, 50 MHz; everything is in this domain.
reset  in  1  asynchronous, active-low reset.
psc_input  in  1  serial line; asynchronous to clk.
rx_byte  out  8  last deframed data byte.
rx_byte_valid  out  1  one-cycle strobe; rx_byte is valid on this cycle.
byte_index  out  4  position in the packet of the byte on rx_byte (0..PKT_BYTES-1).
trigger_out  out  1  one-cycle pulse on a CRC-good packet whose byte 0 equals TRIGGER_HDR.
pkt_done  out  1  one-cycle pulse on any CRC-good packet.
crc_error  out  1  one-cycle pulse when the last byte completes and the CRC residue is not 0.
frame_error  out  1  one-cycle pulse on a bad stop bit.

Behaviour:
- Reset values: all outputs 0, both FSMs idle, CRC register 8'h00.
- Input path: 2-FF synchroniser on psc_input, adding 2 cycles of latency. All sampling uses the synchronised signal.
- Word format: line idles 0. Each word is start=1, then data[7:0] MSB first, then stop=0, giving 10 bits. Words may be back-to-back.
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a 0->1 edge; the bit counter loads CLKS_PER_BIT/2 (integer).
  - START: at mid-bit, if the line is 1, go to DATA; otherwise return to IDLE. This is glitch rejection and produces no error.
  - DATA: sample every CLKS_PER_BIT cycles and shift left into the data register; after 8 samples go to STOP.
  - STOP: sample once at mid-bit.
    - Line 0: rx_byte_valid is asserted on the next cycle; return to IDLE.
    - Line 1: frame_error pulses, the packet is discarded, and the FSM returns to IDLE. The 1 is not re-used as a start bit.
- Packet FSM:
  - Byte counter runs 0..PKT_BYTES-1; byte_index = counter value for the strobed byte.
  - CRC-8 uses poly 0x07, init 0x00, MSB first. It is updated with every byte including the CRC byte, so residue 0 means good.
  - Byte 0 is latched as the header.
  - On the byte with index PKT_BYTES-1:
    - Residue 0: pkt_done pulses on the same cycle as that rx_byte_valid. trigger_out also pulses on that cycle if the header equals TRIGGER_HDR.
    - Non-zero residue: crc_error pulses on that cycle.
    - In both cases the counter and CRC then return to 0.
- Gap timeout: the line held 0 for GAP_BITS*CLKS_PER_BIT cycles while the counter is non-zero resets the counter and CRC silently.
- frame_error also resets the counter and CRC.
- Simultaneous events: a gap timeout cannot coincide with a byte strobe, because a strobe implies recent line activity. Frame error takes priority over CRC evaluation.
- Reset asserted mid-word or mid-packet: immediate return to idle with no pulses. After release, the block waits for the next 0->1 edge.
- End-to-end latency: trigger_out is 2 (sync) + 1 cycles after the stop-bit mid-sample.

Decomposition:
- Package psc_trigger_rx_pkg holds:
  - CRC8_POLY = 8'h07 and CRC8_INIT = 8'h00;
  - WORD_BITS = 10, START_LEVEL = 1, STOP_LEVEL = 0;
  - the bit-FSM state enum.
- The transmitter reuses the CRC and framing constants from this package.
- Sub-module psc_trigger_deserializer contains the synchroniser, the bit FSM and the framing error logic. It outputs byte, strobe and frame_error.
- The top level contains the packet counter, CRC, header compare and gap timer.

Test Plan:
- PKT_BYTES=2: send words A5 then 72 back-to-back.
  - Expected: rx_byte_valid twice with byte_index 0 then 1.
  - Expected: pkt_done and trigger_out pulse once each; crc_error stays 0.
- PKT_BYTES=2: send A5 then 73.
  - Expected: crc_error pulses once; trigger_out and pkt_done stay 0.
  - Then send A5, 72: trigger pulses, proving the CRC was cleared.
- Send A5 with the stop bit forced to 1.
  - Expected: frame_error pulses and no byte strobe.
  - A following good A5, 72 still triggers.
- Send A5, then idle 25 bit-times, then A5, 72.
  - Expected: the gap resets the packet; a single trigger fires on the second packet.
- Apply a 2-cycle high glitch on an idle line.
  - Expected: no strobe and no error.
- Send one good-CRC packet whose header is 3C.
  - Expected: pkt_done pulses and trigger_out does not.
- Assert reset during the 5th data bit, release, then send A5, 72.
  - Expected: exactly one trigger and no spurious outputs.

Source files
------------

// File: rtl/psc_trigger_rx_pkg.sv
// Shared constants and types for the PSC trigger serial link (receive and transmit ends).
package psc_trigger_rx_pkg;

  localparam logic [7:0]  CRC8_POLY   = 8'h07;
  localparam logic [7:0]  CRC8_INIT   = 8'h00;
  localparam int unsigned WORD_BITS   = 10;
  localparam logic        START_LEVEL = 1'b1;
  localparam logic        STOP_LEVEL  = 1'b0;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } bit_state_e;

  // CRC-8 over one byte, MSB first.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ data[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ CRC8_POLY;
    end
    return c;
  endfunction

endpackage

// File: rtl/psc_trigger_deserializer.sv
// Line synchroniser, bit-level FSM and stop-bit framing check for the PSC trigger link.
module psc_trigger_deserializer
  import psc_trigger_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       psc_input,
  output logic       line,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       frame_error
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic            sync1_q, sync2_q, line_prev_q;
  bit_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      data_q, data_d;
  logic [7:0]      byte_q, byte_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  assign line          = sync2_q;
  assign rx_byte       = byte_q;
  assign rx_byte_valid = valid_q;
  assign frame_error   = ferr_q;

  // Two-stage synchroniser plus previous-sample register for start-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      line_prev_q <= 1'b0;
    end else begin
      sync1_q     <= psc_input;
      sync2_q     <= sync1_q;
      line_prev_q <= sync2_q;
    end
  end

  // Bit FSM state and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  // Next-state logic: cnt_q counts down to the next sample point.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if ((line == START_LEVEL) && (line_prev_q != START_LEVEL)) begin
          state_d = StStart;
          cnt_d   = CntW'(CLKS_PER_BIT / 2);
        end
      end
      StStart: begin
        if (cnt_q == '0) begin
          if (line == START_LEVEL) begin
            state_d   = StData;
            cnt_d     = CntW'(CLKS_PER_BIT - 1);
            bit_cnt_d = '0;
          end else begin
            // Short glitch: drop silently.
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StData: begin
        if (cnt_q == '0) begin
          data_d = {data_q[6:0], line};
          cnt_d  = CntW'(CLKS_PER_BIT - 1);
          if (bit_cnt_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == '0) begin
          if (line == STOP_LEVEL) begin
            byte_d  = data_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
          // A high stop bit leaves line_prev_q high, so it cannot start a new word.
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: rtl/psc_trigger_receiver.sv
// PSC trigger link receiver: packet assembly, CRC-8 check, header compare and gap timeout.
module psc_trigger_receiver
  import psc_trigger_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5,
  parameter int unsigned PKT_BYTES    = 8,
  parameter logic [7:0]  TRIGGER_HDR  = 8'hA5,
  parameter int unsigned GAP_BITS     = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       psc_input,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic [3:0] byte_index,
  output logic       trigger_out,
  output logic       pkt_done,
  output logic       crc_error,
  output logic       frame_error
);

  localparam int unsigned GapLimit = GAP_BITS * CLKS_PER_BIT;
  localparam int unsigned GapW     = $clog2(GapLimit + 1);

  logic            line;
  logic [3:0]      count_q, count_d;
  logic [7:0]      crc_q, crc_d;
  logic [7:0]      header_q, header_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [7:0]      crc_next;
  logic            last_byte;
  logic            gap_timeout;

  psc_trigger_deserializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_deser (
    .clk          (clk),
    .reset        (reset),
    .psc_input    (psc_input),
    .line         (line),
    .rx_byte      (rx_byte),
    .rx_byte_valid(rx_byte_valid),
    .frame_error  (frame_error)
  );

  assign crc_next    = crc8_update(crc_q, rx_byte);
  assign last_byte   = (count_q == 4'(PKT_BYTES - 1));
  assign gap_timeout = (gap_q == GapW'(GapLimit)) && (count_q != '0);
  assign byte_index  = count_q;

  // Packet verdicts coincide with the strobe of the final byte.
  assign pkt_done    = rx_byte_valid && last_byte && (crc_next == 8'h00) && !frame_error;
  assign trigger_out = pkt_done && (header_q == TRIGGER_HDR);
  assign crc_error   = rx_byte_valid && last_byte && (crc_next != 8'h00) && !frame_error;

  // Packet state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= '0;
      crc_q    <= CRC8_INIT;
      header_q <= '0;
      gap_q    <= '0;
    end else begin
      count_q  <= count_d;
      crc_q    <= crc_d;
      header_q <= header_d;
      gap_q    <= gap_d;
    end
  end

  // Byte counter, running CRC, header latch and idle-line timer.
  always_comb begin
    count_d  = count_q;
    crc_d    = crc_q;
    header_d = header_q;
    gap_d    = gap_q;

    if (line) begin
      gap_d = '0;
    end else if (gap_q != GapW'(GapLimit)) begin
      gap_d = gap_q + 1'b1;
    end

    if (frame_error) begin
      count_d = '0;
      crc_d   = CRC8_INIT;
    end else if (rx_byte_valid) begin
      if (count_q == '0) header_d = rx_byte;
      if (last_byte) begin
        count_d = '0;
        crc_d   = CRC8_INIT;
      end else begin
        count_d = count_q + 1'b1;
        crc_d   = crc_next;
      end
    end else if (gap_timeout) begin
      count_d = '0;
      crc_d   = CRC8_INIT;
    end
  end

endmodule

// File: tb/tb_psc_trigger_receiver.sv
// Scoreboard bench for psc_trigger_receiver with two-byte packets.
module tb_psc_trigger_receiver;

  localparam int unsigned Cpb = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       psc_input;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic [3:0] byte_index;
  logic       trigger_out;
  logic       pkt_done;
  logic       crc_error;
  logic       frame_error;

  int compared   = 0;
  int mismatched = 0;

  // {valid, index, byte, pkt_done, trigger, crc_error, frame_error}
  logic [16:0] sb[$];

  always #10 clk = ~clk;

  psc_trigger_receiver #(
    .CLKS_PER_BIT(Cpb),
    .PKT_BYTES   (2),
    .TRIGGER_HDR (8'hA5),
    .GAP_BITS    (20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .psc_input    (psc_input),
    .rx_byte      (rx_byte),
    .rx_byte_valid(rx_byte_valid),
    .byte_index   (byte_index),
    .trigger_out  (trigger_out),
    .pkt_done     (pkt_done),
    .crc_error    (crc_error),
    .frame_error  (frame_error)
  );

  function automatic logic [16:0] ev(input logic v, input logic [3:0] idx, input logic [7:0] b,
                                     input logic d, input logic t, input logic c,
                                     input logic f);
    return {v, idx, b, d, t, c, f};
  endfunction

  // Monitor: any active output strobe is one observed event.
  always @(negedge clk) begin
    logic [16:0] obs;
    logic [16:0] exp;
    if (reset && (rx_byte_valid || pkt_done || trigger_out || crc_error || frame_error)) begin
      obs = rx_byte_valid ? ev(1'b1, byte_index, rx_byte, pkt_done, trigger_out, crc_error,
                               frame_error)
                          : ev(1'b0, 4'h0, 8'h00, pkt_done, trigger_out, crc_error,
                               frame_error);
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_event: got %h, required none", obs);
      end else begin
        exp = sb.pop_front();
        if (obs !== exp) begin
          mismatched++;
          $display("FAIL event: got %h, required %h", obs, exp);
        end
      end
    end
  end

  task automatic idle_bits(input int n);
    psc_input = 1'b0;
    repeat (n * Cpb) @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] d, input logic stop);
    psc_input = 1'b1;
    repeat (Cpb) @(negedge clk);
    for (int i = 7; i >= 0; i--) begin
      psc_input = d[i];
      repeat (Cpb) @(negedge clk);
    end
    psc_input = stop;
    repeat (Cpb) @(negedge clk);
  endtask

  task automatic check_quiet(input string name);
    compared++;
    if ({rx_byte, rx_byte_valid, byte_index, trigger_out, pkt_done, crc_error,
         frame_error} !== 17'h0) begin
      mismatched++;
      $display("FAIL %s: outputs %h %b %h %b%b%b%b, required all zero", name, rx_byte,
               rx_byte_valid, byte_index, trigger_out, pkt_done, crc_error, frame_error);
    end
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 2000;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s_timeout: %0d events pending, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    reset     = 1'b0;
    psc_input = 1'b0;
    repeat (5) @(negedge clk);
    check_quiet("reset_state");
    reset = 1'b1;
    @(negedge clk);
    check_quiet("after_release");
    idle_bits(4);

    // Good trigger packet.
    sb.push_back(ev(1'b1, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0));
    sb.push_back(ev(1'b1, 4'd1, 8'h72, 1'b1, 1'b1, 1'b0, 1'b0));
    send_word(8'hA5, 1'b0);
    send_word(8'h72, 1'b0);
    idle_bits(4);
    drain("good_pkt");

    // Bad CRC, then a good packet proves the CRC was cleared.
    sb.push_back(ev(1'b1, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0));
    sb.push_back(ev(1'b1, 4'd1, 8'h73, 1'b0, 1'b0, 1'b1, 1'b0));
    sb.push_back(ev(1'b1, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0));
    sb.push_back(ev(1'b1, 4'd1, 8'h72, 1'b1, 1'b1, 1'b0, 1'b0));
    send_word(8'hA5, 1'b0);
    send_word(8'h73, 1'b0);
    idle_bits(4);
    send_word(8'hA5, 1'b0);
    send_word(8'h72, 1'b0);
    idle_bits(4);
    drain("crc_err");

    // Framing error: no strobe, then a good packet.
    sb.push_back(ev(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
    sb.push_back(ev(1'b1, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0));
    sb.push_back(ev(1'b1, 4'd1, 8'h72, 1'b1, 1'b1, 1'b0, 1'b0));
    send_word(8'hA5, 1'b1);
    idle_bits(4);
    send_word(8'hA5, 1'b0);
    send_word(8'h72, 1'b0);
    idle_bits(4);
    drain("frame_err");

    // Gap timeout discards the half packet; second A5 is byte 0 again.
    sb.push_back(ev(1'b1, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0));
    sb.push_back(ev(1'b1, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0));
    sb.push_back(ev(1'b1, 4'd1, 8'h72, 1'b1, 1'b1, 1'b0, 1'b0));
    send_word(8'hA5, 1'b0);
    idle_bits(25);
    send_word(8'hA5, 1'b0);
    send_word(8'h72, 1'b0);
    idle_bits(4);
    drain("gap");

    // Two-cycle glitch on an idle line.
    psc_input = 1'b1;
    repeat (2) @(negedge clk);
    idle_bits(6);

    // Good CRC, non-trigger header.
    sb.push_back(ev(1'b1, 4'd0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0));
    sb.push_back(ev(1'b1, 4'd1, 8'hB4, 1'b1, 1'b0, 1'b0, 1'b0));
    send_word(8'h3C, 1'b0);
    send_word(8'hB4, 1'b0);
    idle_bits(4);
    drain("hdr_3c");

    // Reset in the 5th data bit of A5 (1010_0101: bits sent 1,0,1,0 then 0).
    psc_input = 1'b1;
    repeat (Cpb) @(negedge clk);
    for (int i = 7; i >= 4; i--) begin
      psc_input = (i[0] == 1'b1) ? 1'b1 : 1'b0;
      repeat (Cpb) @(negedge clk);
    end
    psc_input = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_quiet("mid_reset");
    repeat (4) @(negedge clk);
    check_quiet("held_reset");
    reset = 1'b1;
    idle_bits(4);
    sb.push_back(ev(1'b1, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0));
    sb.push_back(ev(1'b1, 4'd1, 8'h72, 1'b1, 1'b1, 1'b0, 1'b0));
    send_word(8'hA5, 1'b0);
    send_word(8'h72, 1'b0);
    idle_bits(10);
    drain("post_reset");

    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL leftover: %0d events pending, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
